// File: rtl/uart_msg_sequencer.sv
// Buffered message transmitter driving the uart core through its tx_data/tx_wr/tx_busy handshake.
// Sends the first msg_len buffer characters once per start, or repeatedly with a programmable gap.
module uart_msg_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int GAP_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic [ADDR_W:0]   msg_len,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic              repeat_en,
  input  logic              start,
  input  logic              abort,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   char_idx
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STROBE    = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t             state_r;
  logic [DATA_W-1:0]  buffer_r [0:(2**ADDR_W)-1];
  logic [ADDR_W:0]    len_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic               abort_r;
  logic               abort_now_s;
  logic [ADDR_W:0]    idx_next_s;
  logic [GAP_W:0]     gap_next_s;

  // Next-index, next-gap-count and live-or-latched abort terms
  always_comb begin
    abort_now_s = abort_r | abort;
    idx_next_s  = char_idx + {{ADDR_W{1'b0}}, 1'b1};
    gap_next_s  = {1'b0, gap_cnt_r} + {{GAP_W{1'b0}}, 1'b1};
  end

  // Host buffer writes; contents survive reset
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      buffer_r[cfg_addr] <= cfg_wdata;
    end
  end

  // Sequencer FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      tx_data   <= {DATA_W{1'b0}};
      tx_wr     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      char_idx  <= {(ADDR_W+1){1'b0}};
      len_r     <= {(ADDR_W+1){1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
      abort_r   <= 1'b0;
    end else begin
      tx_wr   <= 1'b0;
      done    <= 1'b0;
      abort_r <= (state_r != IDLE) & abort_now_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (msg_len != {(ADDR_W+1){1'b0}}) begin
              len_r    <= msg_len;
              char_idx <= {(ADDR_W+1){1'b0}};
              tx_data  <= buffer_r[{ADDR_W{1'b0}}];
              state_r  <= STROBE;
              busy     <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        STROBE: begin
          // Abort here wins over the write so no strobe is issued
          if (abort_now_s) begin
            abort_r <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (!tx_busy) begin
            tx_wr   <= 1'b1;
            state_r <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            state_r <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            char_idx <= idx_next_s;
            if (abort_now_s) begin
              abort_r <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= IDLE;
            end else if (idx_next_s < len_r) begin
              tx_data <= buffer_r[idx_next_s[ADDR_W-1:0]];
              state_r <= STROBE;
            end else if (repeat_en) begin
              char_idx  <= {(ADDR_W+1){1'b0}};
              len_r     <= msg_len;
              gap_cnt_r <= {GAP_W{1'b0}};
              done      <= 1'b1;
              state_r   <= GAP;
            end else begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        GAP: begin
          if (abort_now_s || !repeat_en || (len_r == {(ADDR_W+1){1'b0}})) begin
            abort_r <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (gap_next_s >= {1'b0, gap_cycles}) begin
            tx_data <= buffer_r[{ADDR_W{1'b0}}];
            state_r <= STROBE;
          end else begin
            gap_cnt_r <= gap_next_s[GAP_W-1:0];
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
